// File: rtl/clint_timer.sv
// -----------------------------------------------------------------------------
// clint_timer
//   Multi-channel machine timer. A shared 64-bit mtime counter advances once
//   every PRESC+1 cycles while RUN is set. Each of NUM_CH 64-bit mtimecmp
//   comparators drives its own maskable, registered interrupt line.
//
// Ports
//   clk           system clock
//   rst           asynchronous, active-high reset
//   address       CPU byte address (word aligned), decoded relative to BASE_ADDR
//   write_data    CPU write data
//   write_enable  CPU write strobe, one write per asserted cycle
//   read_data     combinational read data for address (pre-write state)
//   irq           per-channel interrupt, registered: IE[i] & (mtime >= cmp[i])
//
// Register map (offsets from BASE_ADDR)
//   0x00 MTIME_LO  0x04 MTIME_HI
//   0x08 CTRL      bit0 RUN, bits[8+i] IE[i], bits[16+:PRESC_W] PRESC
//   0x0C PEND      raw compare result per channel (read only)
//   0x10+8i CMP_LO[i], 0x14+8i CMP_HI[i]
// -----------------------------------------------------------------------------
module clint_timer #(
   parameter logic [31:0] BASE_ADDR = 32'hFFFF0000,
   parameter int          NUM_CH    = 2,
   parameter int          PRESC_W   = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       address,
   input  logic [31:0]       write_data,
   input  logic              write_enable,
   output logic [31:0]       read_data,
   output logic [NUM_CH-1:0] irq
);

   localparam logic [31:0] OFF_MTIME_LO = 32'h00;
   localparam logic [31:0] OFF_MTIME_HI = 32'h04;
   localparam logic [31:0] OFF_CTRL     = 32'h08;
   localparam logic [31:0] OFF_PEND     = 32'h0C;
   localparam logic [31:0] OFF_CMP      = 32'h10;

   // Offset within the window; addresses below BASE_ADDR wrap to large
   // values and therefore fall into the unmapped default.
   logic [31:0] off;
   assign off = address - BASE_ADDR;

   logic [63:0]        mtime_q, mtime_d;
   logic [PRESC_W-1:0] pcnt_q,  pcnt_d;
   logic [PRESC_W-1:0] presc_q, presc_d;
   logic               run_q,   run_d;
   logic [NUM_CH-1:0]  ie_q,    ie_d;
   logic [NUM_CH-1:0]  irq_q,   irq_d;
   logic [63:0]        cmp_q [NUM_CH];
   logic [63:0]        cmp_d [NUM_CH];
   logic [NUM_CH-1:0]  pend;

   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         pend[i] = (mtime_q >= cmp_q[i]);
      end
   end

   always_comb begin
      mtime_d = mtime_q;
      pcnt_d  = pcnt_q;
      presc_d = presc_q;
      run_d   = run_q;
      ie_d    = ie_q;
      for (int i = 0; i < NUM_CH; i++) begin
         cmp_d[i] = cmp_q[i];
      end

      if (run_q) begin
         if (pcnt_q == presc_q) begin
            mtime_d = mtime_q + 64'd1;
            pcnt_d  = '0;
         end else begin
            pcnt_d  = pcnt_q + 1'b1;
         end
      end

      // Register writes come after the increment so a written mtime half
      // overrides it: no increment, no carry into the other half.
      if (write_enable) begin
         case (off)
            OFF_MTIME_LO: begin
               mtime_d = {mtime_q[63:32], write_data};
               pcnt_d  = '0;
            end
            OFF_MTIME_HI: begin
               mtime_d = {write_data, mtime_q[31:0]};
               pcnt_d  = '0;
            end
            OFF_CTRL: begin
               run_d   = write_data[0];
               ie_d    = write_data[8 +: NUM_CH];
               presc_d = write_data[16 +: PRESC_W];
               pcnt_d  = '0;
            end
            default: ;
         endcase
         for (int i = 0; i < NUM_CH; i++) begin
            if (off == OFF_CMP + 32'(8 * i)) begin
               cmp_d[i][31:0] = write_data;
            end
            if (off == OFF_CMP + 32'(8 * i + 4)) begin
               cmp_d[i][63:32] = write_data;
            end
         end
      end

      irq_d = ie_q & pend;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mtime_q <= '0;
         pcnt_q  <= '0;
         presc_q <= '0;
         run_q   <= 1'b1;
         ie_q    <= '0;
         irq_q   <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            cmp_q[i] <= '1;
         end
      end else begin
         mtime_q <= mtime_d;
         pcnt_q  <= pcnt_d;
         presc_q <= presc_d;
         run_q   <= run_d;
         ie_q    <= ie_d;
         irq_q   <= irq_d;
         for (int i = 0; i < NUM_CH; i++) begin
            cmp_q[i] <= cmp_d[i];
         end
      end
   end

   always_comb begin
      read_data = '0;
      case (off)
         OFF_MTIME_LO: read_data = mtime_q[31:0];
         OFF_MTIME_HI: read_data = mtime_q[63:32];
         OFF_CTRL: begin
            read_data[0]              = run_q;
            read_data[8 +: NUM_CH]    = ie_q;
            read_data[16 +: PRESC_W]  = presc_q;
         end
         OFF_PEND: read_data[NUM_CH-1:0] = pend;
         default: ;
      endcase
      for (int i = 0; i < NUM_CH; i++) begin
         if (off == OFF_CMP + 32'(8 * i)) begin
            read_data = cmp_q[i][31:0];
         end
         if (off == OFF_CMP + 32'(8 * i + 4)) begin
            read_data = cmp_q[i][63:32];
         end
      end
   end

   assign irq = irq_q;

endmodule

// File: tb/tb_clint_timer.sv
// -----------------------------------------------------------------------------
// tb_clint_timer
//   Scoreboard bench for clint_timer. The driver issues one bus cycle per
//   clock, pushes the expected read_data/irq for that cycle, and advances a
//   reference model in which mtime is derived arithmetically as
//   base + running_cycles / (PRESC+1). A monitor pops and compares.
// -----------------------------------------------------------------------------
module tb_clint_timer;

   localparam logic [31:0] BASE   = 32'hFFFF0000;
   localparam int          NCH    = 2;
   localparam int          PW     = 16;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [31:0]     address = BASE;
   logic [31:0]     write_data = '0;
   logic            write_enable = 1'b0;
   logic [31:0]     read_data;
   logic [NCH-1:0]  irq;

   clint_timer #(.BASE_ADDR(BASE), .NUM_CH(NCH), .PRESC_W(PW)) dut (
      .clk(clk), .rst(rst), .address(address), .write_data(write_data),
      .write_enable(write_enable), .read_data(read_data), .irq(irq)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [63:0]     m_base;
   logic [63:0]     m_elapsed;
   logic [31:0]     m_presc;
   bit              m_run;
   logic [NCH-1:0]  m_ie;
   logic [NCH-1:0]  m_irq;
   logic [63:0]     m_cmp [NCH];

   function automatic logic [63:0] m_mtime();
      return m_base + m_elapsed / (64'(m_presc) + 64'd1);
   endfunction

   function automatic logic [NCH-1:0] m_pend(input logic [63:0] t);
      logic [NCH-1:0] p;
      for (int i = 0; i < NCH; i++) p[i] = (t >= m_cmp[i]);
      return p;
   endfunction

   task automatic m_reset();
      m_base = '0; m_elapsed = '0; m_presc = 0; m_run = 1'b1;
      m_ie = '0; m_irq = '0;
      for (int i = 0; i < NCH; i++) m_cmp[i] = '1;
   endtask

   function automatic logic [31:0] m_read(input logic [31:0] a);
      logic [31:0] o;
      logic [63:0] t;
      o = a - BASE;
      t = m_mtime();
      if (o == 32'h0) return t[31:0];
      if (o == 32'h4) return t[63:32];
      if (o == 32'h8) return (m_presc << 16) | (32'(m_ie) << 8) | 32'(m_run);
      if (o == 32'hC) return 32'(m_pend(t));
      for (int i = 0; i < NCH; i++) begin
         if (o == 32'h10 + 32'(8 * i)) return m_cmp[i][31:0];
         if (o == 32'h14 + 32'(8 * i)) return m_cmp[i][63:32];
      end
      return 32'h0;
   endfunction

   task automatic m_step(input logic [31:0] a, input logic [31:0] d, input bit we);
      logic [63:0]    pre, post;
      logic [NCH-1:0] irq_new;
      logic [31:0]    o;
      o       = a - BASE;
      pre     = m_mtime();
      irq_new = m_ie & m_pend(pre);
      if (m_run) m_elapsed = m_elapsed + 64'd1;
      post = m_mtime();
      if (we) begin
         if (o == 32'h0) begin m_base = {pre[63:32], d}; m_elapsed = '0; end
         if (o == 32'h4) begin m_base = {d, pre[31:0]};  m_elapsed = '0; end
         if (o == 32'h8) begin
            m_base = post; m_elapsed = '0;
            m_run = d[0]; m_ie = d[8 +: NCH]; m_presc = {16'h0, d[31:16]};
         end
         for (int i = 0; i < NCH; i++) begin
            if (o == 32'h10 + 32'(8 * i)) m_cmp[i][31:0]  = d;
            if (o == 32'h14 + 32'(8 * i)) m_cmp[i][63:32] = d;
         end
      end
      m_irq = irq_new;
   endtask

   // ---------------- scoreboard ----------------
   typedef struct {
      logic [31:0]    addr;
      logic [31:0]    rdata;
      logic [NCH-1:0] irq;
   } exp_t;
   exp_t sb[$];

   task automatic cycle(input logic [31:0] a, input logic [31:0] d, input bit we);
      @(negedge clk);
      address = a; write_data = d; write_enable = we;
      sb.push_back('{a, m_read(a), m_irq});
      @(posedge clk);
      m_step(a, d, we);
   endtask

   task automatic wr(input logic [31:0] o, input logic [31:0] d);
      cycle(BASE + o, d, 1'b1);
   endtask

   task automatic rd(input logic [31:0] o, input int n);
      repeat (n) cycle(BASE + o, 32'h0, 1'b0);
   endtask

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk($sformatf("rdata@%h", e.addr), read_data, e.rdata);
            chk("irq", 32'(irq), 32'(e.irq));
         end
      end
   end

   // Reads reset values combinationally while rst is held.
   task automatic reset_reads();
      logic [31:0] offs [10] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14,
                                 32'h18, 32'h1C, 32'h20, 32'h40};
      write_enable = 1'b0;
      chk("irq_in_reset", 32'(irq), 32'h0);
      for (int k = 0; k < 10; k++) begin
         address = BASE + offs[k];
         #1;
         chk($sformatf("reset_rd@%h", offs[k]), read_data, m_read(BASE + offs[k]));
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] pool [11] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14,
                                 32'h18, 32'h1C, 32'h20, 32'h40, 32'h1000_0000};
      logic [31:0] o, d;
      logic [63:0] t;

      m_reset();
      repeat (2) @(posedge clk);
      #3;
      reset_reads();
      @(posedge clk);
      #3;
      rst = 1'b0;

      // Reset values via the scoreboard, including an unmapped offset.
      rd(32'h08, 1); rd(32'h10, 1); rd(32'h14, 1); rd(32'h18, 1); rd(32'h1C, 1); rd(32'h40, 1);

      // Compare on channel 0: PEND and irq[0] one cycle later; irq[1] masked.
      wr(32'h14, 32'h0);
      wr(32'h10, 32'd10);
      wr(32'h08, 32'h0000_0101);
      wr(32'h00, 32'h0);
      rd(32'h0C, 14);

      // Prescaler 3, then frozen with RUN=0, then resumed.
      wr(32'h08, 32'h0003_0101);
      rd(32'h00, 20);
      wr(32'h08, 32'h0003_0100);
      rd(32'h00, 20);
      wr(32'h08, 32'h0003_0101);
      rd(32'h00, 9);

      // Wrap: channel 1 fires at all-ones and drops after wrap to 0.
      wr(32'h08, 32'h0000_0201);
      wr(32'h1C, 32'hFFFF_FFFF);
      wr(32'h18, 32'hFFFF_FFFF);
      wr(32'h04, 32'hFFFF_FFFF);
      wr(32'h00, 32'hFFFF_FFFE);
      rd(32'h0C, 6);
      rd(32'h04, 2);

      // MTIME_LO write on an increment cycle: write wins, HI unchanged.
      wr(32'h04, 32'h0000_0007);
      wr(32'h00, 32'd5);
      rd(32'h00, 1);
      rd(32'h04, 1);
      rd(32'h00, 2);

      // IE clear and CMP rewrite drop irq with their documented lags.
      wr(32'h08, 32'h0000_0301);
      wr(32'h14, 32'h0); wr(32'h10, 32'h0);
      rd(32'h0C, 3);
      wr(32'h08, 32'h0000_0201);
      rd(32'h0C, 3);
      wr(32'h08, 32'h0000_0301);
      rd(32'h0C, 3);
      wr(32'h14, 32'hFFFF_FFFF);
      rd(32'h0C, 3);

      // Randomised traffic.
      for (int n = 0; n < 400; n++) begin
         o = pool[$urandom_range(0, 10)];
         t = m_mtime();
         if ($urandom_range(0, 3) == 0) begin
            case (o)
               32'h08: d = ($urandom_range(0, 3) << 16) | ($urandom_range(0, 3) << 8)
                           | ($urandom & 32'h0000_00FE) | 32'($urandom_range(0, 3) != 0);
               32'h04, 32'h14, 32'h1C:
                  d = ($urandom_range(0, 9) == 0) ? $urandom : t[63:32];
               32'h00, 32'h10, 32'h18:
                  d = t[31:0] + $urandom_range(0, 40);
               default: d = $urandom;
            endcase
            cycle(BASE + o, d, 1'b1);
         end else begin
            cycle(BASE + o, 32'h0, 1'b0);
         end
      end

      // Async reset while irq[0] is high with a non-zero prescaler.
      wr(32'h14, 32'h0); wr(32'h10, 32'h0);
      wr(32'h08, 32'h0002_0101);
      rd(32'h0C, 4);
      #1;
      chk("irq0_before_reset", 32'(irq[0]), 32'h1);
      #2;
      rst = 1'b1;
      m_reset();
      #1;
      reset_reads();
      @(posedge clk);
      #3;
      rst = 1'b0;
      rd(32'h00, 3);
      rd(32'h08, 1);
      rd(32'h10, 1);

      @(negedge clk);
      write_enable = 1'b0;
      repeat (2) @(negedge clk);
      #4;
      chk("scoreboard_drained", 32'(sb.size()), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
